logic_unit_pipe: RTL
====================

Name: logic_unit_pipe

Overview:
Parametrised, two-stage pipelined bitwise logic unit for the ALU datapath. It is the successor to the fixed 32-bit combinational OR slice.
- Selects AND/OR/XOR/NOR per transaction.
- Registers the result and ALU flags (zero, overflow, carry_out, negative).
- Uses a valid/ready handshake on both sides, so it can sit between the operand-fetch and writeback stages under backpressure.

Parameters:
WIDTH, 32, operand/result width in bits (>=2)
OP_W, 2, width of op select; fixed at 2 for this generation

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/op valid this cycle
in_ready  output  1  unit can accept operands this cycle
op  input  OP_W  00=AND, 01=OR, 10=XOR, 11=NOR
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result/flags valid
out_ready  input  1  downstream accepts result this cycle
result  output  WIDTH  registered logic result
zero  output  1  result == 0
overflow  output  1  always 0 for logic ops; kept for ALU flag uniformity
carry_out  output  1  always 0 for logic ops
negative  output  1  result[WIDTH-1]

Behaviour:
- Reset (rst_n low, asynchronous, any cycle):
  - s1_valid and s2_valid clear.
  - out_valid=0, result=0, zero=0, overflow=0, carry_out=0, negative=0.
  - Stage-1 operand registers clear to 0.
  - In-flight transactions are discarded, never emitted.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_valid may be asserted independent of in_ready.
  - Once out_valid is high, result and flags are held stable until the transfer.
- Pipeline:
  - Stage 1 (S1) registers a, b and op on input transfer.
  - Stage 2 (S2) computes the op on the S1 contents and registers result and flags. out_valid = s2_valid.
- Control:
  - s2_advance = !s2_valid || out_ready
  - s1_advance = s1_valid && s2_advance
  - in_ready = !s1_valid || s2_advance (combinational from out_ready; no skid buffer)
- Latency: 2 cycles from input transfer to out_valid with out_ready held high. Throughput 1 per cycle.
- Simultaneous input and output transfer in the same cycle with both stages full: all stages shift, no bubble, no loss.
- Stall: with out_ready=0 the pipeline holds at most 2 transactions. in_ready drops once both stages are full.
- Ordering: strictly in-order, no reordering or dropping.
- Flags are computed from the full WIDTH result:
  - zero = ~|result
  - negative = result[WIDTH-1]
- NOR is the bitwise complement of OR across all WIDTH bits.
- op values are fully decoded; there are no illegal encodings.

Optional Feature:
LOGIC_UNIT_PARITY_EN
- Defined: adds output port parity (1 bit) = ^result, registered in S2 with the other flags and reset to 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - op encoding constants LOP_AND=2'b00, LOP_OR=2'b01, LOP_XOR=2'b10, LOP_NOR=2'b11
  - a flag-bundle struct {zero, overflow, carry_out, negative}
- One natural sub-module: logic_op_comb (combinational, WIDTH-parametrised), computing result and flags from a, b, op. It is instantiated in S2 and reused by later ALU generations.

Test Plan:
1. Reset, then OR WIDTH=32, a=0x0000004F, b=0x0000001B, out_ready=1 -> 2 cycles later out_valid=1, result=0x0000005F, zero=0, negative=0.
2. OR a=0xD5000000, b=0x25000000; then AND a=0xDDD5D5D5, b=0x25DDD5D5 back-to-back -> consecutive results 0xF5000000 (negative=1) and 0x05D5D5D5 (negative=0), no bubble.
3. OR a=0, b=0 -> zero=1, overflow=0, carry_out=0. NOR with WIDTH=8, a=0x00, b=0x00 -> result=0xFF, negative=1, zero=0.
4. Backpressure:
   - Hold out_ready=0 and offer XOR ops 0xF0^0x0F, 0xFF^0xFF, 0xAA^0x55 on consecutive cycles.
   - Required: in_ready drops after 2 accepts, and the third is held at the input.
   - Release out_ready: results emerge in order 0xFF, 0x00 (zero=1), 0xFF.
   - Required: result stays stable while stalled.
5. Assert rst_n low asynchronously with both stages full and out_valid=1 -> out_valid falls immediately, and no stale results emerge after release.
6. With LOGIC_UNIT_PARITY_EN, OR 0x00000007|0 -> parity=1; 0x00000003|0 -> parity=0.

Source files
------------

// File: rtl/logic_unit_pipe_pkg.sv
// Shared ALU definitions: op encodings and the flag bundle carried alongside every result.
package alu_pkg;

    localparam int ALU_OP_W = 2;

    typedef logic [ALU_OP_W-1:0] alu_op_t;

    localparam alu_op_t LOP_AND = 2'b00;
    localparam alu_op_t LOP_OR  = 2'b01;
    localparam alu_op_t LOP_XOR = 2'b10;
    localparam alu_op_t LOP_NOR = 2'b11;

    typedef struct packed {
        logic zero;
        logic overflow;
        logic carry_out;
        logic negative;
    } alu_flags_t;

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for the pipelined logic unit.
// The parity signal exists only when LOGIC_UNIT_PARITY_EN is defined.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 32
);
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    alu_op_t          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             carry_out;
    logic             negative;
`ifdef LOGIC_UNIT_PARITY_EN
    logic             parity;
`endif

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, overflow, carry_out, negative
`ifdef LOGIC_UNIT_PARITY_EN
        , input parity
`endif
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero, overflow, carry_out, negative
`ifdef LOGIC_UNIT_PARITY_EN
        , output parity
`endif
    );

endinterface

// File: rtl/logic_unit_pipe_logic_op_comb.sv
// Purpose: bitwise AND/OR/XOR/NOR of two operands plus ALU flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the enclosing stage decides when to capture.
module logic_op_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          op,
    output logic [WIDTH-1:0] result,
    output alu_flags_t       flags
);

    always_comb begin
        result = '0;
        unique case (op)
            LOP_AND: result = a & b;
            LOP_OR:  result = a | b;
            LOP_XOR: result = a ^ b;
            LOP_NOR: result = ~(a | b);
        endcase
    end

    // Logic ops never overflow or carry; the bits exist so every ALU slice shares one flag shape.
    always_comb begin
        flags           = '0;
        flags.zero      = ~|result;
        flags.overflow  = 1'b0;
        flags.carry_out = 1'b0;
        flags.negative  = result[WIDTH-1];
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Purpose: two-stage pipelined logic unit (S1 captures operands, S2 computes and registers result/flags); LOGIC_UNIT_PARITY_EN adds a registered parity output.
// Latency: 2 cycles from input transfer to out_valid, throughput 1 per cycle.
// Backpressure: holds up to 2 transactions; in_ready follows out_ready combinationally when both stages are full.
module logic_unit_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = ALU_OP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    logic_unit_pipe_if.slave  io
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [OP_W-1:0]  s1_op;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_result;
    alu_flags_t       s2_flags;

    logic             s2_advance;
    logic             s1_advance;
    logic             in_fire;

    logic [WIDTH-1:0] comb_result;
    alu_flags_t       comb_flags;

    assign s2_advance  = !s2_valid || io.out_ready;
    assign s1_advance  = s1_valid && s2_advance;
    assign io.in_ready = !s1_valid || s2_advance;
    assign in_fire     = io.in_valid && io.in_ready;

    // S1 reloads on any input transfer; otherwise it empties only when its entry moves to S2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_a     <= io.a;
            s1_b     <= io.b;
            s1_op    <= io.op;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    logic_op_comb #(
        .WIDTH (WIDTH)
    ) u_logic_op (
        .a      (s1_a),
        .b      (s1_b),
        .op     (s1_op),
        .result (comb_result),
        .flags  (comb_flags)
    );

    // Result and flags only change when S2 is free to accept, so they hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_flags  <= '0;
        end else if (s2_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= comb_result;
                s2_flags  <= comb_flags;
            end
        end
    end

`ifdef LOGIC_UNIT_PARITY_EN
    logic s2_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_parity <= 1'b0;
        end else if (s2_advance && s1_valid) begin
            s2_parity <= ^comb_result;
        end
    end

    assign io.parity = s2_parity;
`endif

    assign io.out_valid = s2_valid;
    assign io.result    = s2_result;
    assign io.zero      = s2_flags.zero;
    assign io.overflow  = s2_flags.overflow;
    assign io.carry_out = s2_flags.carry_out;
    assign io.negative  = s2_flags.negative;

endmodule
